// File: rtl/pipelined_subtractor.sv
// Pipelined ripple-borrow subtractor: diff = a - b - bin, one CHUNK-bit slice per stage, valid/ready stream.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf. WIDTH must be a multiple of CHUNK.
module pipelined_subtractor #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int STAGES = WIDTH / CHUNK;

   function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             bi);
      logic [CHUNK-1:0] d;
      logic             bo;
      d  = '0;
      bo = bi;
      for (int i = 0; i < CHUNK; i++) begin
         d[i] = x[i] ^ y[i] ^ bo;
         bo   = (~x[i] & y[i]) | (bo & ~(x[i] ^ y[i]));
      end
      return {bo, d};
   endfunction

   logic advance;
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   for (genvar s = 0; s < STAGES; s++) begin : g_st
      // Stage s sees only the operand bits not yet resolved; its low CHUNK bits are this slice.
      localparam int IW = WIDTH - s * CHUNK;
      localparam int DW = (s + 1) * CHUNK;

      logic [IW-1:0]  a_in;
      logic [IW-1:0]  b_in;
      logic           bi_in;
      logic           vld_in;
      logic [CHUNK:0] res_d;
      logic [DW-1:0]  diff_d;
      logic [DW-1:0]  diff_q;
      logic           bor_q;
      logic           vld_q;

      if (s == 0) begin : g_head
         assign a_in   = a;
         assign b_in   = b;
         assign bi_in  = bin;
         assign vld_in = in_valid;
         assign diff_d = res_d[CHUNK-1:0];
      end else begin : g_body
         assign a_in   = g_st[s-1].g_fwd.a_q;
         assign b_in   = g_st[s-1].g_fwd.b_q;
         assign bi_in  = g_st[s-1].bor_q;
         assign vld_in = g_st[s-1].vld_q;
         assign diff_d = {res_d[CHUNK-1:0], g_st[s-1].diff_q};
      end

      assign res_d = sub_chunk(a_in[CHUNK-1:0], b_in[CHUNK-1:0], bi_in);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= 1'b0;
            bor_q  <= 1'b0;
            diff_q <= '0;
         end else if (advance) begin
            vld_q  <= vld_in;
            bor_q  <= res_d[CHUNK];
            diff_q <= diff_d;
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic [IW-CHUNK-1:0] a_q;
         logic [IW-CHUNK-1:0] b_q;

         // Operand bits are pure data: bubbles carry don't-care values guarded by vld_q.
         always_ff @(posedge clk) begin
            if (advance) begin
               a_q <= a_in[IW-1:CHUNK];
               b_q <= b_in[IW-1:CHUNK];
            end
         end
      end
   end

   assign out_valid = g_st[STAGES-1].vld_q;
   assign diff      = g_st[STAGES-1].diff_q;
   assign bout      = g_st[STAGES-1].bor_q;

`ifdef SUB_OVF_EN
   logic a_msb;
   logic b_msb;
   logic ovf_d;
   logic ovf_q;

   // The sign bits ride along as the top of the unresolved operand slice into the last stage.
   assign a_msb = g_st[STAGES-1].a_in[CHUNK-1];
   assign b_msb = g_st[STAGES-1].b_in[CHUNK-1];
   assign ovf_d = (a_msb ^ b_msb) & (g_st[STAGES-1].res_d[CHUNK-1] ^ a_msb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (advance) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: doc/pipelined_subtractor.md
# pipelined_subtractor

Parametrised, pipelined N-bit ripple-borrow subtractor computing `diff = a - b - bin` with a valid/ready stream handshake. The operand is split into CHUNK-bit slices, one slice per pipeline stage, and the borrow is registered between stages, so the critical path stays one CHUNK-bit ripple regardless of WIDTH. It is the datapath subtractor for wide operands in the arithmetic library and replaces chained fixed-width subtractors where throughput of one result per cycle is needed.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- a  input  WIDTH  minuend, unsigned bit vector.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in to bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out from bit WIDTH-1 (1 when a < b + bin, unsigned).
- ovf  output  1  signed overflow; present only with SUB_OVF_EN.

## Operation
- Per-bit rule: d = a^b^bi; bo = (~a&b) | (bi&~(a^b)).
- Stage s (0..STAGES-1) resolves bits [s*CHUNK +: CHUNK] using the registered borrow from stage s-1 (stage 0 uses bin). It registers: the partial diff, the borrow, the still-unprocessed upper operand bits, and a valid bit.
- Global advance = out_ready | ~out_valid. All stages shift together when advance=1. In that cycle, every stage's valid bit takes the previous stage's valid, and stage 0 loads in_valid.
- in_ready = advance (combinational; no dependency on in_valid).
- Accept = in_valid & in_ready. Bubbles (valid=0) propagate like data; their data contents are don't-care but must not corrupt neighbours.
- Output registers (diff, bout, ovf, out_valid) are the last stage's registers.
- Stall: while out_valid & ~out_ready, no stage register changes. in_ready=0, and diff/bout/ovf hold stable.
- Reset (rst_n=0, any time): all valid bits, out_valid, diff, bout and ovf go to 0 immediately. In-flight transactions are discarded. After release, in_ready=1 because out_valid=0.

## Timing
- Latency: a transaction accepted at rising edge k appears with out_valid=1 after edge k+STAGES-1. This is the same edge for STAGES=1, i.e. registered output visible in the cycle after acceptance.
- Throughput: 1 transaction/cycle with out_ready held high. No bubble is inserted between back-to-back accepts.
- Output handshake: a result is consumed at an edge where out_valid & out_ready. A new result may appear on the same edge.
- Ordering strictly FIFO; no reordering or dropping except on reset.
- in_ready falls in the same cycle out_valid & ~out_ready holds. It rises in the cycle out_ready rises.
- Reset values: in_ready=1 (derived), out_valid=0, diff=0, bout=0, ovf=0.

## Configuration
- SUB_OVF_EN defined:
  - ovf port exists.
  - The sign bits a[WIDTH-1] and b[WIDTH-1] are carried through the pipeline.
  - ovf = (a_msb ^ b_msb) & (diff[WIDTH-1] ^ a_msb), registered alongside diff.
- SUB_OVF_EN undefined: ovf port and its pipeline registers are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, CHUNK=4, single transaction a=0x0000, b=0x0001, bin=0 -> exactly 4 cycles later out_valid=1, diff=0xFFFF, bout=1.
- a=0x1234, b=0x0234, bin=1 -> diff=0x0FFF, bout=0. a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
- Back-to-back, with out_ready=1:
  - 100 random accepts on consecutive cycles -> 100 results, in order, on consecutive cycles.
  - Each result matches the golden model {bout,diff} = a - b - bin (17-bit).
- Backpressure:
  - Stream 10 transactions with out_ready=0 for cycles 6-8 -> in_ready=0 while stalled, and diff held constant.
  - No loss or duplication; results arrive in order after release.
- Reset mid-flight: assert rst_n=0 with 3 transactions in flight -> out_valid=0, diff=0, bout=0 immediately. No stale result appears after release. The next accept yields its result 4 cycles later.
- SUB_OVF_EN defined:
  - 0x8000 - 0x0001 -> diff=0x7FFF, ovf=1.
  - 0x7FFF - 0xFFFF -> diff=0x8000, ovf=1.
  - 0x0005 - 0x0003 -> ovf=0.
  - Repeat one case with WIDTH=8, CHUNK=8 -> latency 1 cycle.
